// File: rtl/phase_sequencer_if.sv
// -----------------------------------------------------------------------------
// phase_sequencer_if
//   Groups the control and status signals of the phase sequencer into one bundle.
//   The slave modport is the sequencer. The master modport is whatever drives the
//   front-panel pulses and datapath status, and reads the phase enables.
//
//   exec_pulse  : 1-cycle start / pause request
//   step_pulse  : 1-cycle single-step request
//   mode_phase  : step granularity (0 = instruction, 1 = phase)
//   haltin      : datapath decoded HALT (meaningful on a firing phase)
//   stall       : datapath not ready, hold the current phase
//   phase_en    : one-hot enable of the phase executing this cycle
//   phase_idx   : current phase index
//   state       : FSM state (PAUSE=0, RUN=1, STEP=2, HALT=3)
//   running     : RUN or STEP
//   halted      : HALT
//   fault       : stall watchdog tripped (sticky)
//   instr_count : retired instructions, wraps
// -----------------------------------------------------------------------------
interface phase_sequencer_if #(
  parameter int NPHASE = 5,
  parameter int CNTW   = 16
);
  logic              exec_pulse;
  logic              step_pulse;
  logic              mode_phase;
  logic              haltin;
  logic              stall;
  logic [NPHASE-1:0] phase_en;
  logic [2:0]        phase_idx;
  logic [2:0]        state;
  logic              running;
  logic              halted;
  logic              fault;
  logic [CNTW-1:0]   instr_count;

  modport slave (
    input  exec_pulse, step_pulse, mode_phase, haltin, stall,
    output phase_en, phase_idx, state, running, halted, fault, instr_count
  );

  modport master (
    output exec_pulse, step_pulse, mode_phase, haltin, stall,
    input  phase_en, phase_idx, state, running, halted, fault, instr_count
  );
endinterface

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
//   Sequences the phases of a multi-phase datapath. It supports run, pause,
//   single-instruction step and single-phase step. A phase is held while the
//   datapath stalls. The sequencer stops at the instruction boundary after a
//   HALT and counts retired instructions. A watchdog faults into HALT when the
//   datapath stalls for too long.
//
//   clock : system clock, all logic on posedge
//   reset : synchronous, active-high
//   bus   : phase_sequencer_if.slave (control pulses in, phase enables/status out)
//
//   All outputs are registered. A cycle "fires" when the sequencer is in RUN or
//   STEP and stall is low. On that edge, phase_en shows the phase that fired, and
//   phase_idx has already advanced to the next phase.
// -----------------------------------------------------------------------------
module phase_sequencer #(
  parameter int NPHASE    = 5,
  parameter int CNTW      = 16,
  parameter int STALL_MAX = 255
) (
  input logic              clock,
  input logic              reset,
  phase_sequencer_if.slave bus
);

  localparam int       SCW  = $clog2(STALL_MAX + 1);
  localparam bit [2:0] LAST = 3'(NPHASE - 1);

  typedef enum logic [2:0] {
    PAUSE = 3'd0,
    RUN   = 3'd1,
    STEP  = 3'd2,
    HALT  = 3'd3
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        phase_q;
  logic              step_phase_q;   // granularity latched when STEP is entered
  logic              halt_pend_q;
  logic              pause_pend_q;
  logic [SCW-1:0]    stall_cnt_q;
  logic [CNTW-1:0]   count_q;
  logic              fault_q;
  logic [NPHASE-1:0] phase_en_q, phase_en_d;
  logic              running_q, running_d;
  logic              halted_q, halted_d;

  logic active, fire, boundary, halt_now, trip;

  // NOTE: every signal assigned in an always_comb gets a default first.
  // This means no path leaves it unassigned, so no latch is inferred.
  always_comb begin
    active   = (state_q == RUN) || (state_q == STEP);
    fire     = active && !bus.stall;
    boundary = fire && (phase_q == LAST);
    // A HALT decoded on the final phase still halts at that same boundary.
    halt_now = halt_pend_q || (fire && bus.haltin);
    trip     = active && bus.stall && (stall_cnt_q == SCW'(STALL_MAX - 1));
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PAUSE: begin
        if (bus.exec_pulse)      state_d = RUN;   // exec wins over a same-cycle step
        else if (bus.step_pulse) state_d = STEP;
      end
      RUN: begin
        if (trip)                                        state_d = HALT;
        else if (boundary && halt_now)                   state_d = HALT;
        else if (boundary && (pause_pend_q || bus.exec_pulse)) state_d = PAUSE;
      end
      STEP: begin
        if (trip)                                        state_d = HALT;
        else if (boundary && halt_now)                   state_d = HALT;
        else if (fire && (step_phase_q || boundary))     state_d = PAUSE;
      end
      HALT:    state_d = HALT;                        // only reset leaves HALT
      default: state_d = PAUSE;
    endcase
  end

  // Output logic (values loaded into the output registers)
  always_comb begin
    phase_en_d = '0;
    if (fire) phase_en_d[phase_q] = 1'b1;
    running_d = (state_d == RUN) || (state_d == STEP);
    halted_d  = (state_d == HALT);
  end

  // State register and datapath registers
  // NOTE: sequential state uses non-blocking assignments. Every register then
  // samples its pre-edge value, and ordering between blocks cannot matter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= PAUSE;
      phase_q      <= '0;
      step_phase_q <= 1'b0;
      halt_pend_q  <= 1'b0;
      pause_pend_q <= 1'b0;
      stall_cnt_q  <= '0;
      count_q      <= '0;
      fault_q      <= 1'b0;
      phase_en_q   <= '0;
      running_q    <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_en_q <= phase_en_d;
      running_q  <= running_d;
      halted_q   <= halted_d;

      if (fire) phase_q <= boundary ? 3'd0 : phase_q + 3'd1;
      if (boundary) count_q <= count_q + 1'b1;

      // The watchdog counts consecutive active stalled cycles only.
      stall_cnt_q <= (active && bus.stall) ? stall_cnt_q + 1'b1 : '0;
      if (trip) fault_q <= 1'b1;

      if (state_d == HALT)          halt_pend_q <= 1'b0;
      else if (fire && bus.haltin)  halt_pend_q <= 1'b1;

      // A pause request is only meaningful while RUN continues.
      pause_pend_q <= (state_d == RUN) &&
                      (pause_pend_q || ((state_q == RUN) && bus.exec_pulse));

      if ((state_q == PAUSE) && !bus.exec_pulse && bus.step_pulse)
        step_phase_q <= bus.mode_phase;
    end
  end

  assign bus.phase_en    = phase_en_q;
  assign bus.phase_idx   = phase_q;
  assign bus.state       = state_q;
  assign bus.running     = running_q;
  assign bus.halted      = halted_q;
  assign bus.fault       = fault_q;
  assign bus.instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
//   Scoreboard bench for phase_sequencer. The driver applies stimulus on the
//   falling edge. It steps a behavioural model of the sequencing rules and pushes
//   the expected post-edge outputs into a queue. A monitor samples the DUT just
//   after each rising edge, then pops and compares.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

  localparam int NPHASE    = 5;
  localparam int CNTW      = 16;
  localparam int STALL_MAX = 255;

  typedef struct packed {
    logic [NPHASE-1:0] en;
    logic [2:0]        idx;
    logic [2:0]        st;
    logic              run;
    logic              hlt;
    logic              flt;
    logic [CNTW-1:0]   cnt;
  } obs_t;

  logic clock;
  logic reset;

  phase_sequencer_if #(.NPHASE(NPHASE), .CNTW(CNTW)) bus ();

  phase_sequencer #(.NPHASE(NPHASE), .CNTW(CNTW), .STALL_MAX(STALL_MAX)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc_no = 0;

  // ---------------- behavioural model ----------------
  // Modes use the externally visible encoding: 0 pause, 1 run, 2 step, 3 halt.
  int m_mode, m_phase, m_count, m_stalled, m_en;
  bit m_fault, m_halt_req, m_pause_req, m_step_by_phase;

  task automatic model_tick(input bit r, e, s, md, h, st);
    bit executing, fired, retire;
    int nxt;
    if (r) begin
      m_mode = 0; m_phase = 0; m_count = 0; m_stalled = 0; m_en = 0;
      m_fault = 0; m_halt_req = 0; m_pause_req = 0; m_step_by_phase = 0;
      return;
    end
    executing = (m_mode == 1) || (m_mode == 2);
    fired     = executing && !st;
    retire    = fired && (m_phase == NPHASE - 1);
    m_en      = fired ? (1 << m_phase) : 0;
    nxt       = m_mode;
    if (fired && h) m_halt_req = 1;
    m_stalled = (executing && st) ? m_stalled + 1 : 0;
    if (m_stalled == STALL_MAX) begin
      m_fault = 1;
      nxt = 3;
    end else if (m_mode == 0) begin
      if (e) nxt = 1;
      else if (s) begin nxt = 2; m_step_by_phase = md; end
    end else if (m_mode == 1) begin
      if (e) m_pause_req = 1;
      if (retire) nxt = m_halt_req ? 3 : (m_pause_req ? 0 : 1);
    end else if (m_mode == 2) begin
      if (retire && m_halt_req) nxt = 3;
      else if (fired && (m_step_by_phase || retire)) nxt = 0;
    end
    if (fired) m_phase = (m_phase + 1) % NPHASE;
    if (retire) m_count = (m_count + 1) % (1 << CNTW);
    if (nxt != 1) m_pause_req = 0;
    if (nxt == 3) m_halt_req = 0;
    m_mode = nxt;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.en  = NPHASE'(m_en);
    o.idx = 3'(m_phase);
    o.st  = 3'(m_mode);
    o.run = (m_mode == 1) || (m_mode == 2);
    o.hlt = (m_mode == 3);
    o.flt = m_fault;
    o.cnt = CNTW'(m_count);
    return o;
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit r, e, s, md, h, st);
    @(negedge clock);
    reset          = r;
    bus.exec_pulse = e;
    bus.step_pulse = s;
    bus.mode_phase = md;
    bus.haltin     = h;
    bus.stall      = st;
    model_tick(r, e, s, md, h, st);
    exp_q.push_back(model_obs());
  endtask

  task automatic idle(input int n, input bit st = 0);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, st);
  endtask

  // ---------------- monitor ----------------
  always begin
    obs_t act, exp;
    @(posedge clock);
    #1;
    cyc_no++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act.en  = bus.phase_en;
      act.idx = bus.phase_idx;
      act.st  = bus.state;
      act.run = bus.running;
      act.hlt = bus.halted;
      act.flt = bus.fault;
      act.cnt = bus.instr_count;
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL outputs @cycle %0d: got en=%b idx=%0d st=%0d run=%b hlt=%b flt=%b cnt=%0d, expected en=%b idx=%0d st=%0d run=%b hlt=%b flt=%b cnt=%0d",
                 cyc_no, act.en, act.idx, act.st, act.run, act.hlt, act.flt, act.cnt,
                 exp.en, exp.idx, exp.st, exp.run, exp.hlt, exp.flt, exp.cnt);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1;
    bus.exec_pulse = 0; bus.step_pulse = 0; bus.mode_phase = 0;
    bus.haltin = 0; bus.stall = 0;

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);

    // Free run: the phases rotate and one instruction retires every five fires.
    drive(0, 1, 0, 0, 0, 0);
    idle(12);
    // Pause request mid-instruction, completed at the boundary.
    while (m_phase != 2) idle(1);
    drive(0, 1, 0, 0, 0, 0);
    idle(6);

    // Phase stepping: three single-phase steps from phase 0.
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 1, 0, 0);
      idle(3);
    end
    // Instruction step from a mid-instruction phase, plus pulses inside STEP.
    drive(0, 0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    idle(6);

    // Stall bursts in RUN; exec+step together in PAUSE selects RUN.
    drive(0, 1, 1, 1, 0, 0);
    idle(3, 1);
    idle(4);
    for (int k = 0; k < 30; k++)
      drive(0, 0, 0, 0, 0, $urandom_range(0, 2) == 0);

    // HALT decoded on a phase-1 fire.
    while (!(m_mode == 1 && m_phase == 1)) idle(1);
    drive(0, 0, 0, 0, 1, 0);
    idle(6);
    drive(0, 1, 1, 0, 0, 0);
    idle(3);

    // HALT decoded on the last phase halts at that same boundary.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    while (m_phase != NPHASE - 1) idle(1);
    drive(0, 0, 0, 0, 1, 0);
    idle(3);

    // Watchdog trips after an uninterrupted stall.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    idle(2);
    idle(STALL_MAX + 4, 1);
    idle(2);

    // Reset in the middle of phase 3.
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    while (m_phase != 3) idle(1);
    drive(1, 0, 0, 0, 0, 0);
    idle(2);

    // Randomized traffic, with occasional resets so HALT is left again.
    for (int k = 0; k < 3000; k++)
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 14) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 59) == 0, $urandom_range(0, 3) == 0);

    // Drain the scoreboard (bounded).
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clock);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
